imm_narrow_unit: RTL and testbench
==================================

IMM_NARROW_UNIT -- requirements
Module: imm_narrow_unit

Interface
REQ-001 SHALL have parameter IN_W, default 32, the width of the wide operand.
REQ-002 SHALL have parameter OUT_W, default 15, the width of the narrow immediate field.
REQ-003 SHALL have parameter CNT_W, default 8, the width of the overflow counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the input word this cycle.
REQ-008 SHALL have port in_data, input, IN_W bits: the wide value to narrow.
REQ-009 SHALL have port in_cs, input, 1 bit: the narrowing mode; 0 = unsigned (zero-extension inverse), 1 = signed (sign-extension inverse).
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_imm, output, OUT_W bits: the narrowed immediate.
REQ-013 SHALL have port out_fit, output, 1 bit: in_data is exactly representable in OUT_W bits under in_cs.
REQ-014 SHALL have port cnt_clr, input, 1 bit: synchronous clear of ovf_cnt.
REQ-015 SHALL have port ovf_cnt, output, CNT_W bits: the saturating count of delivered non-fitting results.

Function
REQ-016 SHALL be a 2-stage valid/ready pipeline (S1 fit-check register, S2 output register) with latency 2 cycles from the input handshake to out_valid and throughput of 1 word per cycle.
REQ-017 SHALL transfer on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
REQ-018 SHALL set stage-advance rules: S2 loads when !out_valid||out_ready; S1 advances into S2 when S2 loads; in_ready = !s1_valid||S2 loads (combinational, no registered ready).
REQ-019 SHALL hold out_imm, out_fit and out_valid stable while out_valid&&!out_ready, and SHALL NOT drop or duplicate a word.
REQ-020 SHALL compute fit when in_cs=0 as in_data[IN_W-1:OUT_W]==0.
REQ-021 SHALL compute fit when in_cs=1 as in_data[IN_W-1:OUT_W-1] all bits equal.
REQ-022 SHALL drive out_imm = in_data[OUT_W-1:0] when fit=1, so that re-extending it with the same in_cs reproduces in_data exactly.
REQ-023 SHALL drive out_imm = in_data[OUT_W-1:0] (truncation) when fit=0 and IMM_NARROW_SAT_EN is undefined.
REQ-024 SHALL increment ovf_cnt on each output handshake with out_fit=0, saturating at 2^CNT_W-1 and never wrapping.
REQ-025 SHALL give cnt_clr priority over a same-cycle increment, leaving ovf_cnt=0.

Reset
REQ-026 SHALL, while rst_n=0, immediately force s1_valid=0, out_valid=0, out_imm=0, out_fit=0 and ovf_cnt=0.
REQ-027 SHALL discard in-flight words on reset mid-operation, and SHALL make in_ready=1 in the first cycle after release.

Configuration
REQ-028 SHALL, when IMM_NARROW_SAT_EN is defined and fit=0, saturate out_imm: in_cs=0 gives all ones (0x7FFF); in_cs=1 with a positive value gives 0x3FFF; in_cs=1 with a negative value gives 0x4000; out_fit SHALL still report 0.
REQ-029 SHALL, when IMM_NARROW_SAT_EN is undefined, truncate per REQ-023, with no saturation logic present.

Structure
REQ-030 SHALL place the IN_W/OUT_W/CNT_W defaults, the mode encodings (CS_UNSIGNED=0, CS_SIGNED=1) and the saturation constants in the shared package imm_pkg.
REQ-031 SHALL implement the combinational fit/saturate function as sub-module imm_fit_check, instantiated once between in_data and the S1 register.

Verification
REQ-032 SHALL cover this scenario: in_cs=1, in_data=0xFFFFC000, out_ready=1 -> 2 cycles later out_imm=0x4000, out_fit=1, ovf_cnt=0.
REQ-033 SHALL cover this scenario: in_cs=0, in_data=0x00008000 -> out_fit=0, ovf_cnt=1, out_imm=0x0000 without the macro and 0x7FFF with it.
REQ-034 SHALL cover this scenario: back-to-back words 0x1,0x2,0x3 with out_ready low for 3 cycles after the first out_valid -> in_ready falls after 2 held words, all 3 words are delivered in order, no loss.
REQ-035 SHALL cover this scenario: 300 non-fitting signed words (0x00010000) -> ovf_cnt saturates at 255; cnt_clr pulsed together with an overflow handshake -> ovf_cnt=0.
REQ-036 SHALL cover this scenario: rst_n pulsed low while 2 words are in flight -> out_valid=0 asynchronously, ovf_cnt=0, in_ready=1 after release.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate narrowing unit.
//   Default widths for the wide operand, the narrow immediate field and the
//   overflow counter, the narrowing-mode encoding, and generators for the
//   saturation values used when the unit is built with IMM_NARROW_SAT_EN.
//   The generators return 32-bit values; callers keep the low w bits.
//   At the default width of 15 they give 0x7FFF (unsigned), 0x3FFF (signed
//   positive) and 0x4000 (signed negative).
package imm_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 15;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    CS_UNSIGNED = 1'b0,
    CS_SIGNED   = 1'b1
  } cs_e;

  // Largest unsigned value of a w-bit field: all ones.
  function automatic logic [31:0] sat_unsigned(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Largest positive two's-complement value of a w-bit field.
  function automatic logic [31:0] sat_signed_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement value of a w-bit field (sign bit only).
  function automatic logic [31:0] sat_signed_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// imm_fit_check -- combinational fit check and narrowing of one wide word.
//   Build option: IMM_NARROW_SAT_EN -- when defined, words that do not fit
//   are clamped to the nearest representable value; otherwise they are
//   truncated to their low OUT_W bits.
// Ports:
//   data [IN_W]  : wide value to narrow
//   cs           : narrowing mode (0 = unsigned, 1 = signed)
//   imm  [OUT_W] : narrowed immediate
//   fit          : data is exactly representable in OUT_W bits under cs
module imm_fit_check
  import imm_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  data,
  input  logic             cs,
  output logic [OUT_W-1:0] imm,
  output logic             fit
);

  logic [IN_W-OUT_W-1:0] upper_u;
  logic [IN_W-OUT_W:0]   upper_s;

  // Signed check includes the field's own sign bit: all of it must match.
  assign upper_u = data[IN_W-1:OUT_W];
  assign upper_s = data[IN_W-1:OUT_W-1];

  always_comb begin
    fit = 1'b0;
    if (cs_e'(cs) == CS_SIGNED) fit = (&upper_s) | ~(|upper_s);
    else                        fit = ~(|upper_u);
  end

`ifdef IMM_NARROW_SAT_EN
  localparam logic [OUT_W-1:0] SAT_U   = OUT_W'(sat_unsigned(OUT_W));
  localparam logic [OUT_W-1:0] SAT_POS = OUT_W'(sat_signed_pos(OUT_W));
  localparam logic [OUT_W-1:0] SAT_NEG = OUT_W'(sat_signed_neg(OUT_W));

  always_comb begin
    imm = data[OUT_W-1:0];
    if (!fit) begin
      if (cs_e'(cs) == CS_SIGNED) imm = data[IN_W-1] ? SAT_NEG : SAT_POS;
      else                        imm = SAT_U;
    end
  end
`else
  assign imm = data[OUT_W-1:0];
`endif

endmodule

// File: rtl/imm_narrow_unit.sv
// imm_narrow_unit -- two-stage valid/ready pipeline that narrows a wide
//   operand to an OUT_W-bit immediate, flags whether it fits, and counts
//   delivered non-fitting results in a saturating counter.
//   Build option: IMM_NARROW_SAT_EN (see imm_fit_check).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_data [IN_W]      : wide value
//   in_cs               : narrowing mode (0 = unsigned, 1 = signed)
//   out_valid/out_ready : output handshake
//   out_imm [OUT_W]     : narrowed immediate
//   out_fit             : value was representable
//   cnt_clr             : synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt [CNT_W]     : saturating count of delivered non-fitting results
module imm_narrow_unit
  import imm_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_cs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_fit,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  logic             s1_valid;
  logic [OUT_W-1:0] s1_imm;
  logic             s1_fit;
  logic [OUT_W-1:0] fc_imm;
  logic             fc_fit;
  logic             s2_load;
  logic             out_hs;

  imm_fit_check #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_fit_check (
    .data (in_data),
    .cs   (in_cs),
    .imm  (fc_imm),
    .fit  (fc_fit)
  );

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_hs   = out_valid && out_ready;

  // S1: when it can move, it takes whatever is offered (possibly a bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_fit   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_imm <= fc_imm;
        s1_fit <= fc_fit;
      end
    end
  end

  // S2: data only changes when a new word arrives, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fit   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_imm <= s1_imm;
        out_fit <= s1_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_hs && !out_fit && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_narrow_unit.sv
// tb_imm_narrow_unit -- directed, self-checking bench for imm_narrow_unit
//   at default parameters. Expected immediates for non-fitting words depend
//   on whether IMM_NARROW_SAT_EN is defined.
module tb_imm_narrow_unit;

`ifdef IMM_NARROW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_cs;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_imm;
  logic        out_fit;
  logic        cnt_clr;
  logic [7:0]  ovf_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  imm_narrow_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cs     (in_cs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fit   (out_fit),
    .cnt_clr   (cnt_clr),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated word with out_ready high: result visible two edges later.
  task automatic single(input string tag, input logic [31:0] d, input logic cs,
                        input logic [31:0] e_imm, input logic e_fit);
    in_valid = 1'b1; in_data = d; in_cs = cs;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_imm"}, {17'd0, out_imm}, e_imm);
    chk({tag, "_fit"}, {31'd0, out_fit}, {31'd0, e_fit});
    tick();
  endtask

  task automatic burst(input int n);
    in_valid = 1'b1; in_data = 32'h0001_0000; in_cs = 1'b1;
    repeat (n) tick();
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cs = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_imm",   {17'd0, out_imm},   32'd0);
    chk("rst_out_fit",   {31'd0, out_fit},   32'd0);
    chk("rst_ovf_cnt",   {24'd0, ovf_cnt},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Signed negative that fits exactly.
    single("s_neg_fit", 32'hFFFF_C000, 1'b1, 32'h4000, 1'b1);
    chk("s_neg_fit_ovf", {24'd0, ovf_cnt}, 32'd0);
    // Unsigned overflow.
    single("u_ovf", 32'h0000_8000, 1'b0, SAT ? 32'h7FFF : 32'h0000, 1'b0);
    chk("u_ovf_cnt", {24'd0, ovf_cnt}, 32'd1);
    single("s_pos_fit", 32'h0000_3FFF, 1'b1, 32'h3FFF, 1'b1);
    single("s_pos_ovf", 32'h0000_4000, 1'b1, SAT ? 32'h3FFF : 32'h4000, 1'b0);
    single("s_neg_ovf", 32'hFFFF_8000, 1'b1, SAT ? 32'h4000 : 32'h0000, 1'b0);
    single("u_max_fit", 32'h0000_7FFF, 1'b0, 32'h7FFF, 1'b1);
    chk("mix_ovf_cnt", {24'd0, ovf_cnt}, 32'd3);

    // Back-to-back with output stall for 3 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_cs = 1'b0; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_data = 32'h3;
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_imm",   {17'd0, out_imm},   32'h1);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) tick();
    chk("bp_hold_imm",   {17'd0, out_imm},   32'h1);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_w2_imm", {17'd0, out_imm}, 32'h2);
    tick();
    chk("bp_w3_imm",   {17'd0, out_imm},   32'h3);
    chk("bp_w3_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_ovf_cnt", {24'd0, ovf_cnt},   32'd3);

    // Clear alone.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_only", {24'd0, ovf_cnt}, 32'd0);

    // Saturation: 254, then 255, then 45 more stay at 255 (300 total).
    in_valid = 1'b1; in_data = 32'h0001_0000; in_cs = 1'b1;
    tick();
    tick();
    chk("sat_word_fit", {31'd0, out_fit}, 32'd0);
    chk("sat_word_imm", {17'd0, out_imm}, SAT ? 32'h3FFF : 32'h0000);
    repeat (252) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_254", {24'd0, ovf_cnt}, 32'd254);
    burst(1);
    chk("cnt_255", {24'd0, ovf_cnt}, 32'd255);
    burst(45);
    chk("cnt_sat_hold", {24'd0, ovf_cnt}, 32'd255);

    // Clear together with an overflow handshake.
    in_valid = 1'b1; in_data = 32'h0001_0000; in_cs = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_hs_valid", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_vs_inc", {24'd0, ovf_cnt}, 32'd0);

    // Reset with two words in flight.
    in_valid = 1'b1; in_data = 32'h0000_8000; in_cs = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre_rst_ovf",   {24'd0, ovf_cnt},   32'd1);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ovf",   {24'd0, ovf_cnt},   32'd0);
    chk("async_rst_imm",   {17'd0, out_imm},   32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    chk("post_rst_no_word", {31'd0, out_valid}, 32'd0);
    chk("post_rst_ovf",     {24'd0, ovf_cnt},   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
